// File: rtl/alu_pkg.sv
// Shared types for the iterative ALU: operation codes and top-level FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_NOR   = 3'b010,
    OP_SLT   = 3'b011,
    OP_SLTU  = 3'b100,
    OP_MULLO = 3'b101,
    OP_MULHI = 3'b110,
    OP_RSVD  = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    HOLD
  } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per clock.
// Ports:
//   clk, reset (async, active-high)
//   start      : load a/b and begin WIDTH iterations
//   a, b       : multiplicand / multiplier, sampled on start
//   busy       : iterations in progress
//   done       : one-cycle pulse, prod holds the final product
//   prod       : 2*WIDTH product accumulator
module alu_mul_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   upper;

  // Upper half plus optional multiplicand; bit WIDTH is the carry that
  // shifts back into the accumulator MSB.
  always_comb begin
    upper = {1'b0, prod[2*WIDTH-1:WIDTH]};
    if (mplier[0]) upper = upper + {1'b0, mcand};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand  <= a;
        mplier <= b;
        prod   <= '0;
        cnt    <= CNT_W'(WIDTH);
        busy   <= 1'b1;
      end else if (busy) begin
        prod   <= {upper, prod[WIDTH-1:1]};
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Handshaked ALU: single-cycle add/sub/nor/slt/sltu, iterative multiply.
// Ports:
//   clk, reset (async, active-high)
//   in_valid/in_ready   : request handshake, op/A/B sampled on accept
//   op, A, B            : operation code and operands
//   out_valid/out_ready : result handshake
//   out, Cout, overflow, Z, neg : registered result and flags
//   busy                : multiply iterations in progress
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             Cout,
  output logic             overflow,
  output logic             Z,
  output logic             neg,
  output logic             busy
);

  alu_state_t state;
  alu_op_t    opc;
  logic       accept;
  logic       is_mul;
  logic       mul_hi;
  logic       mul_done;
  logic [2*WIDTH-1:0] prod;

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] s;
  logic [WIDTH:0]   c;
  logic             add_ovf;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;
  logic [WIDTH-1:0] fin_res;
  logic             fin_c;
  logic             fin_v;

  assign opc      = alu_op_t'(op);
  assign is_mul   = (opc == OP_MULLO) || (opc == OP_MULHI);
  assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept   = in_valid && in_ready;

  alu_mul_iter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_mul (
    .clk  (clk),
    .reset(reset),
    .start(accept && is_mul),
    .a    (A),
    .b    (B),
    .busy (busy),
    .done (mul_done),
    .prod (prod)
  );

  // Ripple adder built from per-bit full-adder cells; everything except ADD
  // runs as A + ~B + 1 so SLT/SLTU can reuse the subtract carries.
  always_comb begin
    bx   = (opc == OP_ADD) ? B : ~B;
    s    = '0;
    c    = '0;
    c[0] = (opc != OP_ADD);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      s[i]   = A[i] ^ bx[i] ^ c[i];
      c[i+1] = (A[i] & bx[i]) | (c[i] & (A[i] ^ bx[i]));
    end
    add_ovf = c[WIDTH] ^ c[WIDTH-1];
  end

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (opc)
      OP_ADD, OP_SUB: begin
        res   = s;
        res_c = c[WIDTH];
        res_v = add_ovf;
      end
      OP_NOR:  res    = ~(A | B);
      OP_SLT:  res[0] = s[WIDTH-1] ^ add_ovf;
      OP_SLTU: res[0] = ~c[WIDTH];
      default: res    = '0;
    endcase
  end

  // One load path for both result sources: the multiplier while in MUL,
  // the single-cycle datapath otherwise.
  always_comb begin
    fin_res = res;
    fin_c   = res_c;
    fin_v   = res_v;
    if (state == MUL) begin
      fin_res = mul_hi ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
      fin_c   = 1'b0;
      fin_v   = !mul_hi && (|prod[2*WIDTH-1:WIDTH]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out       <= '0;
      Cout      <= 1'b0;
      overflow  <= 1'b0;
      Z         <= 1'b0;
      neg       <= 1'b0;
      mul_hi    <= 1'b0;
    end else begin
      case (state)
        MUL: begin
          if (mul_done) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            out       <= fin_res;
            Cout      <= fin_c;
            overflow  <= fin_v;
            Z         <= (fin_res == '0);
            neg       <= fin_res[WIDTH-1];
          end
        end
        default: begin
          // Retire first; a same-edge accept below overrides these.
          if ((state == HOLD) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
          if (accept) begin
            if (is_mul) begin
              state     <= MUL;
              out_valid <= 1'b0;
              mul_hi    <= (opc == OP_MULHI);
            end else begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out       <= fin_res;
              Cout      <= fin_c;
              overflow  <= fin_v;
              Z         <= (fin_res == '0);
              neg       <= fin_res[WIDTH-1];
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: the driver pushes hand-computed expected
// results, a negedge monitor pops and compares on every out_valid&out_ready.
module tb_alu_iter;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         Cout;
  logic         overflow;
  logic         Z;
  logic         neg;
  logic         busy;

  typedef struct packed {
    logic [W-1:0] o;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  alu_iter #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .A        (A),
    .B        (B),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .Cout     (Cout),
    .overflow (overflow),
    .Z        (Z),
    .neg      (neg),
    .busy     (busy)
  );

  function automatic exp_t mk(logic [W-1:0] o, logic c, logic v, logic z, logic n);
    exp_t e;
    e.o = o; e.c = c; e.v = v; e.z = z; e.n = n;
    return e;
  endfunction

  // Monitor: each negedge with valid&ready is exactly one handshake.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      exp_t e;
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL result_unexpected: got out=%h C=%b V=%b Z=%b N=%b, no result required",
                 out, Cout, overflow, Z, neg);
      end else begin
        e = sbq.pop_front();
        if (out !== e.o || Cout !== e.c || overflow !== e.v || Z !== e.z || neg !== e.n) begin
          fails++;
          $display("FAIL result: got out=%h C=%b V=%b Z=%b N=%b, required out=%h C=%b V=%b Z=%b N=%b",
                   out, Cout, overflow, Z, neg, e.o, e.c, e.v, e.z, e.n);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input exp_t e, input bit push);
    int n;
    n = 0;
    if (push) sbq.push_back(e);
    op = o; A = a; B = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sbq.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   lat;
    logic bad;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; A = '0; B = '0;

    #12;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_out", {32'd0, out}, 64'd0);
    chk("reset_flags", {59'd0, Cout, overflow, Z, neg, busy}, 64'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Single-cycle ops, issued back to back
    issue(OP_ADD,  32'h7FFFFFFF, 32'h00000001, mk(32'h80000000, 0, 1, 0, 1), 1);
    issue(OP_SUB,  32'h80000000, 32'h00000001, mk(32'h7FFFFFFF, 1, 1, 0, 0), 1);
    issue(OP_SUB,  32'h00000035, 32'h000000B5, mk(32'hFFFFFF80, 0, 0, 0, 1), 1);
    issue(OP_SLT,  32'h80000000, 32'h7FFFFFFF, mk(32'h00000001, 0, 0, 0, 0), 1);
    issue(OP_SLTU, 32'h80000000, 32'h7FFFFFFF, mk(32'h00000000, 0, 0, 1, 0), 1);
    issue(OP_SLT,  32'h00000001, 32'h00000001, mk(32'h00000000, 0, 0, 1, 0), 1);
    issue(OP_RSVD, 32'h12345678, 32'h9ABCDEF0, mk(32'h00000000, 0, 0, 1, 0), 1);
    issue(OP_NOR,  32'h00000000, 32'h00000000, mk(32'hFFFFFFFF, 0, 0, 0, 1), 1);
    drain();

    // MULLO latency and stall behaviour
    issue(OP_MULLO, 32'h00010000, 32'h00010000, mk(32'h00000000, 0, 1, 1, 0), 1);
    lat = -1;
    bad = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
      if (in_ready !== 1'b0) bad = 1'b1;
      if (n < 32 && busy !== 1'b1) bad = 1'b1;
    end
    chk("mul_latency", 64'(lat), 64'd33);
    chk("mul_busy_inready", {63'd0, bad}, 64'd0);
    @(posedge clk); #1;
    issue(OP_MULHI, 32'h00010000, 32'h00010000, mk(32'h00000001, 0, 0, 0, 0), 1);
    drain();
    issue(OP_MULLO, 32'h00000003, 32'h00000005, mk(32'h0000000F, 0, 0, 0, 0), 1);
    drain();
    issue(OP_MULLO, 32'hFFFFFFFF, 32'hFFFFFFFF, mk(32'h00000001, 0, 1, 0, 0), 1);
    drain();
    issue(OP_MULHI, 32'hFFFFFFFF, 32'hFFFFFFFF, mk(32'hFFFFFFFE, 0, 0, 0, 1), 1);
    drain();

    // Hold with out_ready low, then retire and accept on the same edge
    out_ready = 1'b0;
    issue(OP_ADD, 32'h12345678, 32'h11111111, mk(32'h23456789, 0, 0, 0, 0), 1);
    bad = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (out !== 32'h23456789 || out_valid !== 1'b1 || in_ready !== 1'b0 ||
          Cout !== 1'b0 || overflow !== 1'b0 || Z !== 1'b0 || neg !== 1'b0) bad = 1'b1;
    end
    chk("hold_stable", {63'd0, bad}, 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(OP_NOR, 32'h00000DEF, 32'h00000ABC, mk(32'hFFFFF000, 0, 0, 0, 1), 1);
    drain();

    // Reset in the middle of a multiply
    issue(OP_MULLO, 32'h00000003, 32'h00000005, mk('0, 0, 0, 0, 0), 0);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("midmul_reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midmul_reset_busy", {63'd0, busy}, 64'd0);
    chk("midmul_reset_out", {32'd0, out}, 64'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("in_ready_after_abort", {63'd0, in_ready}, 64'd1);
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    chk("no_stale_result", {63'd0, bad}, 64'd0);
    @(posedge clk); #1;
    issue(OP_ADD, 32'h00000DEF, 32'h00000ABC, mk(32'h000018AB, 0, 0, 0, 0), 1);
    drain();

    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
